mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/lsu_pkg.sv | 60 ++++++
 rtl/load_align.sv | 50 +++++
 rtl/mem_stage_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the MEM-stage load/store unit:
//               FSM state encoding, funct3 load/store codes, NOP encoding and
//               small decode helpers used by the LSU and its load aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    // Access FSM: IDLE accepts a new access, WAIT holds it until dm_ready.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

    // Load funct3 encodings
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // Store funct3 encodings (SW also covers FSW, LW also covers FLW)
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    // addi x0, x0, 0 -- inserted into MEM/WB as a bubble
    localparam logic [31:0] c_NOP_INSN = 32'h0000_0013;

    // Loads accept the signed and unsigned byte/half forms plus word.
    function automatic logic load_f3_legal(input logic [2:0] f3);
        case (f3)
            c_F3_LB, c_F3_LH, c_F3_LW, c_F3_LBU, c_F3_LHU: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Stores only have byte, half and word forms.
    function automatic logic store_f3_legal(input logic [2:0] f3);
        case (f3)
            c_F3_SB, c_F3_SH, c_F3_SW: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Natural alignment: halves on even addresses, words on multiples of 4.
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'b001, 3'b101: return ~lo[0];
            3'b010:         return (lo == 2'b00);
            default:        return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Combinational load data aligner. Picks the addressed byte or
//               halfword out of the returned memory word and sign- or
//               zero-extends it according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection by the low address bits
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Width and extension by funct3
    always_comb begin
        o_result = i_rdata;
        case (i_funct3)
            c_F3_LB:  o_result = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  o_result = {{16{w_half[15]}}, w_half};
            c_F3_LW:  o_result = i_rdata;
            c_F3_LBU: o_result = {24'h000000, w_byte};
            c_F3_LHU: o_result = {16'h0000, w_half};
            default:  o_result = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM pipeline stage with a two-state load/store FSM. Issues
//               word-aligned data-memory requests with byte enables, stalls
//               the pipeline until dm_ready, aligns load data and owns the
//               MEM/WB register. Illegal or misaligned accesses never reach
//               memory and are flagged on mem_err_out for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,              // asynchronous, active-low

    // EX/MEM inputs
    input  logic [31:0] ALU_in,
    input  logic [31:0] StoreData_in,
    input  logic [4:0]  Rd_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] Instruction_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic        FloatRegWrite_in,

    // Data memory port
    output logic        dm_req,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,

    // Pipeline freeze
    output logic        mem_stall,

    // MEM/WB outputs
    output logic [31:0] WBData_out,
    output logic [4:0]  Rd_out,
    output logic        RegWrite_out,
    output logic        FloatRegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] Instruction_out,
    output logic        mem_err_out
);

    lsu_state_e  r_state;

    // Request held stable on the memory port while in WAIT
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    // Instruction context captured at issue, used when the access completes
    logic [31:0] r_alu;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [31:0] r_instr;
    logic        r_is_load;
    logic        r_regwrite;
    logic        r_fregwrite;
    logic        r_memtoreg;

    logic        w_is_mem;
    logic        w_legal;
    logic        w_ok;
    logic        w_start;
    logic        w_err;
    logic        w_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    // Access classification: a simultaneous read and write is never legal
    always_comb begin
        w_is_mem = MemRead_in | MemWrite_in;
        w_legal  = 1'b0;
        if (MemRead_in && !MemWrite_in) begin
            w_legal = load_f3_legal(funct3_in);
        end else if (MemWrite_in && !MemRead_in) begin
            w_legal = store_f3_legal(funct3_in);
        end
        w_ok    = w_legal & f3_aligned(funct3_in, ALU_in[1:0]);
        // rst gating keeps dm_req low the instant reset is asserted
        w_start = rst & (r_state == ST_IDLE) & w_is_mem & w_ok;
        w_err   = (r_state == ST_IDLE) & w_is_mem & ~w_ok;
        w_done  = (r_state == ST_WAIT) & dm_ready;
    end

    // Store lane enables and data replication; loads present no enables
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0000_0000;
        if (MemWrite_in && !MemRead_in) begin
            case (funct3_in)
                c_F3_SB: begin
                    w_be    = 4'b0001 << ALU_in[1:0];
                    w_wdata = {4{StoreData_in[7:0]}};
                end
                c_F3_SH: begin
                    w_be    = 4'b0011 << ALU_in[1:0];
                    w_wdata = {2{StoreData_in[15:0]}};
                end
                c_F3_SW: begin
                    w_be    = 4'b1111;
                    w_wdata = StoreData_in;
                end
                default: begin
                    w_be    = 4'b0000;
                    w_wdata = 32'h0000_0000;
                end
            endcase
        end
    end

    // Memory port: live values in the issue cycle, latched values afterwards
    always_comb begin
        dm_req    = w_start | (r_state == ST_WAIT);
        dm_addr   = w_start ? {ALU_in[31:2], 2'b00} : r_addr;
        dm_be     = w_start ? w_be : r_be;
        dm_wdata  = w_start ? w_wdata : r_wdata;
        mem_stall = w_start | ((r_state == ST_WAIT) & ~dm_ready);
    end

    load_align u_load_align (
        .i_rdata   (dm_rdata),
        .i_addr_lo (r_alu[1:0]),
        .i_funct3  (r_funct3),
        .o_result  (w_load_data)
    );

    // FSM and issue-time capture of the request and its instruction context
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= 32'h0000_0000;
            r_be        <= 4'b0000;
            r_wdata     <= 32'h0000_0000;
            r_alu       <= 32'h0000_0000;
            r_funct3    <= 3'b000;
            r_rd        <= 5'd0;
            r_instr     <= 32'h0000_0000;
            r_is_load   <= 1'b0;
            r_regwrite  <= 1'b0;
            r_fregwrite <= 1'b0;
            r_memtoreg  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_WAIT;
                        r_addr      <= {ALU_in[31:2], 2'b00};
                        r_be        <= w_be;
                        r_wdata     <= w_wdata;
                        r_alu       <= ALU_in;
                        r_funct3    <= funct3_in;
                        r_rd        <= Rd_in;
                        r_instr     <= Instruction_in;
                        r_is_load   <= MemRead_in;
                        r_regwrite  <= RegWrite_in;
                        r_fregwrite <= FloatRegWrite_in;
                        r_memtoreg  <= MemtoReg_in;
                    end
                end
                ST_WAIT: begin
                    if (dm_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, completed access, or pass-through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WBData_out        <= 32'h0000_0000;
            Rd_out            <= 5'd0;
            RegWrite_out      <= 1'b0;
            FloatRegWrite_out <= 1'b0;
            MemtoReg_out      <= 1'b0;
            Instruction_out   <= 32'h0000_0000;
            mem_err_out       <= 1'b0;
        end else if (mem_stall) begin
            WBData_out        <= 32'h0000_0000;
            Rd_out            <= 5'd0;
            RegWrite_out      <= 1'b0;
            FloatRegWrite_out <= 1'b0;
            MemtoReg_out      <= 1'b0;
            Instruction_out   <= c_NOP_INSN;
            mem_err_out       <= 1'b0;
        end else if (w_done) begin
            WBData_out        <= r_is_load ? w_load_data : r_alu;
            Rd_out            <= r_rd;
            RegWrite_out      <= r_regwrite;
            FloatRegWrite_out <= r_fregwrite;
            MemtoReg_out      <= r_memtoreg;
            Instruction_out   <= r_instr;
            mem_err_out       <= 1'b0;
        end else begin
            // Faulting accesses keep their PC context but must not write back
            WBData_out        <= ALU_in;
            Rd_out            <= Rd_in;
            RegWrite_out      <= RegWrite_in & ~w_err;
            FloatRegWrite_out <= FloatRegWrite_in & ~w_err;
            MemtoReg_out      <= MemtoReg_in & ~w_err;
            Instruction_out   <= Instruction_in;
            mem_err_out       <= w_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu: reset values, a table
//               of directed accesses, reset during a pending access, and
//               random accesses checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_in, StoreData_in, Instruction_in;
    logic [4:0]  Rd_in;
    logic [2:0]  funct3_in;
    logic        MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in, FloatRegWrite_in;
    logic        dm_req;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ready;
    logic        mem_stall;
    logic [31:0] WBData_out, Instruction_out;
    logic [4:0]  Rd_out;
    logic        RegWrite_out, FloatRegWrite_out, MemtoReg_out, mem_err_out;

    int n_pass  = 0;
    int n_total = 0;

    mem_stage_lsu dut (
        .clk              (clk),
        .rst              (rst),
        .ALU_in           (ALU_in),
        .StoreData_in     (StoreData_in),
        .Rd_in            (Rd_in),
        .funct3_in        (funct3_in),
        .Instruction_in   (Instruction_in),
        .MemRead_in       (MemRead_in),
        .MemWrite_in      (MemWrite_in),
        .MemtoReg_in      (MemtoReg_in),
        .RegWrite_in      (RegWrite_in),
        .FloatRegWrite_in (FloatRegWrite_in),
        .dm_req           (dm_req),
        .dm_be            (dm_be),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_rdata         (dm_rdata),
        .dm_ready         (dm_ready),
        .mem_stall        (mem_stall),
        .WBData_out       (WBData_out),
        .Rd_out           (Rd_out),
        .RegWrite_out     (RegWrite_out),
        .FloatRegWrite_out(FloatRegWrite_out),
        .MemtoReg_out     (MemtoReg_out),
        .Instruction_out  (Instruction_out),
        .mem_err_out      (mem_err_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        mr, mw, m2r, rw, frw;
        logic [31:0] instr;
        logic [31:0] rdata;
        logic [1:0]  delay;      // WAIT cycles with dm_ready low
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
        logic        exp_err;
    } op_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " dm_req"},    dm_req, 0);
        chk({nm, " dm_be"},     dm_be, 0);
        chk({nm, " dm_addr"},   dm_addr, 0);
        chk({nm, " dm_wdata"},  dm_wdata, 0);
        chk({nm, " stall"},     mem_stall, 0);
        chk({nm, " wbdata"},    WBData_out, 0);
        chk({nm, " rd"},        Rd_out, 0);
        chk({nm, " ctrl"},      {RegWrite_out, FloatRegWrite_out, MemtoReg_out}, 0);
        chk({nm, " instr"},     Instruction_out, 0);
        chk({nm, " err"},       mem_err_out, 0);
    endtask

    // Behavioural reference: derives the expected port activity of one
    // access from the architectural rules, using plain arithmetic.
    function automatic op_t model(input op_t o);
        op_t    r = o;
        int     sz, off;
        bit     legal, ok, is_mem;
        longint v, span;
        off = int'(o.alu[1:0]);
        case (o.f3[1:0])
            2'd0:    sz = 1;
            2'd1:    sz = 2;
            2'd2:    sz = 4;
            default: sz = 0;
        endcase
        is_mem = o.mr | o.mw;
        if (o.mr && o.mw)  legal = 0;
        else if (o.mr)     legal = (o.f3 != 3 && o.f3 != 6 && o.f3 != 7);
        else               legal = (o.f3 <= 2);
        ok = legal && sz != 0 && (off % sz == 0);
        r.exp_err   = is_mem && !ok;
        r.exp_req   = is_mem && ok;
        r.exp_be    = 0;
        r.exp_wdata = 0;
        r.exp_wb    = o.alu;
        if (r.exp_req && o.mw) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + sz) r.exp_be[i] = 1'b1;
                r.exp_wdata[8*i +: 8] = o.sdata[8*(i % sz) +: 8];
            end
        end
        if (r.exp_req && o.mr) begin
            v = longint'(o.rdata >> (8*off));
            if (sz < 4) begin
                span = longint'(1) << (8*sz);
                v = v % span;
                if (!o.f3[2] && v >= span/2) v = v - span;
            end
            r.exp_wb = 32'(v);
        end
        return r;
    endfunction

    // Runs one EX/MEM instruction to completion and checks every cycle of it.
    // Entered shortly after a rising edge with the FSM idle.
    task automatic run_op(input string nm, input op_t o);
        logic [31:0] eaddr = {o.alu[31:2], 2'b00};
        ALU_in = o.alu; StoreData_in = o.sdata; funct3_in = o.f3; Rd_in = o.rd;
        MemRead_in = o.mr; MemWrite_in = o.mw; MemtoReg_in = o.m2r;
        RegWrite_in = o.rw; FloatRegWrite_in = o.frw; Instruction_in = o.instr;
        dm_ready = 1'($urandom % 2);   // must be ignored while idle
        dm_rdata = $urandom;
        #1;
        chk({nm, " issue req"},   dm_req, o.exp_req);
        chk({nm, " issue stall"}, mem_stall, o.exp_req);
        if (!o.exp_req) begin
            tick();
            chk({nm, " wbdata"}, WBData_out, o.exp_wb);
            chk({nm, " regwr"},  RegWrite_out, o.exp_err ? 1'b0 : o.rw);
            chk({nm, " fregwr"}, FloatRegWrite_out, o.exp_err ? 1'b0 : o.frw);
            chk({nm, " err"},    mem_err_out, o.exp_err);
            chk({nm, " instr"},  Instruction_out, o.instr);
            if (!o.exp_err) begin
                chk({nm, " rd"},  Rd_out, o.rd);
                chk({nm, " m2r"}, MemtoReg_out, o.m2r);
            end
        end else begin
            chk({nm, " addr"}, dm_addr, eaddr);
            chk({nm, " be"},   dm_be, o.exp_be);
            if (o.mw) chk({nm, " wdata"}, dm_wdata, o.exp_wdata);
            tick();
            for (int k = 0; k < int'(o.delay); k++) begin
                dm_ready = 1'b0;
                #1;
                chk({nm, " wait req"},    dm_req, 1);
                chk({nm, " wait stall"},  mem_stall, 1);
                chk({nm, " wait addr"},   dm_addr, eaddr);
                chk({nm, " wait be"},     dm_be, o.exp_be);
                if (o.mw) chk({nm, " wait wdata"}, dm_wdata, o.exp_wdata);
                chk({nm, " bubble ctl"},  {RegWrite_out, FloatRegWrite_out, MemtoReg_out, mem_err_out}, 0);
                chk({nm, " bubble ins"},  Instruction_out, NOP);
                tick();
            end
            dm_ready = 1'b1;
            dm_rdata = o.rdata;
            #1;
            chk({nm, " rdy req"},    dm_req, 1);
            chk({nm, " rdy stall"},  mem_stall, 0);
            chk({nm, " rdy addr"},   dm_addr, eaddr);
            chk({nm, " rdy be"},     dm_be, o.exp_be);
            chk({nm, " bubble ctl"}, {RegWrite_out, FloatRegWrite_out, MemtoReg_out, mem_err_out}, 0);
            chk({nm, " bubble ins"}, Instruction_out, NOP);
            tick();
            dm_ready = 1'b0;
            chk({nm, " wbdata"}, WBData_out, o.exp_wb);
            chk({nm, " rd"},     Rd_out, o.rd);
            chk({nm, " ctl"},    {RegWrite_out, FloatRegWrite_out, MemtoReg_out}, {o.rw, o.frw, o.m2r});
            chk({nm, " instr"},  Instruction_out, o.instr);
            chk({nm, " err"},    mem_err_out, 0);
        end
    endtask

    task automatic idle_inputs();
        ALU_in = 0; StoreData_in = 0; funct3_in = 0; Rd_in = 0;
        MemRead_in = 0; MemWrite_in = 0; MemtoReg_in = 0;
        RegWrite_in = 0; FloatRegWrite_in = 0; Instruction_in = NOP;
    endtask

    op_t tbl [16];
    op_t o;

    initial begin
        // alu, sdata, f3, rd, mr, mw, m2r, rw, frw, instr, rdata, delay,
        // exp_req, exp_be, exp_wdata, exp_wb, exp_err
        tbl[0]  = '{32'h1234, 32'h0, 3'd0, 5'd5,  1'b0,1'b0,1'b0,1'b1,1'b0, 32'h00C502B3, 32'h0,        2'd0, 1'b0, 4'h0, 32'h0,        32'h1234,     1'b0};
        tbl[1]  = '{32'h103,  32'h0, 3'd0, 5'd7,  1'b1,1'b0,1'b1,1'b1,1'b0, 32'h10300383, 32'h80FFFFFF, 2'd2, 1'b1, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[2]  = '{32'h102,  32'hABCD, 3'd1, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h10B01123, 32'h0,       2'd0, 1'b1, 4'hC, 32'hABCDABCD, 32'h102,      1'b0};
        tbl[3]  = '{32'h101,  32'h0, 3'd2, 5'd8,  1'b1,1'b0,1'b1,1'b1,1'b0, 32'h10102403, 32'h0,        2'd0, 1'b0, 4'h0, 32'h0,        32'h101,      1'b1};
        tbl[4]  = '{32'h101,  32'h0, 3'd4, 5'd9,  1'b1,1'b0,1'b1,1'b1,1'b0, 32'h1014C483, 32'h1234F678, 2'd1, 1'b1, 4'h0, 32'h0,        32'h000000F6, 1'b0};
        tbl[5]  = '{32'h202,  32'h0, 3'd5, 5'd10, 1'b1,1'b0,1'b1,1'b1,1'b0, 32'h20255503, 32'h80010000, 2'd0, 1'b1, 4'h0, 32'h0,        32'h00008001, 1'b0};
        tbl[6]  = '{32'h200,  32'h0, 3'd1, 5'd11, 1'b1,1'b0,1'b1,1'b1,1'b0, 32'h20051583, 32'h12349ABC, 2'd3, 1'b1, 4'h0, 32'h0,        32'hFFFF9ABC, 1'b0};
        tbl[7]  = '{32'h303,  32'h123456EF, 3'd0, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h30A501A3, 32'h0, 2'd1, 1'b1, 4'h8, 32'hEFEFEFEF, 32'h303,      1'b0};
        tbl[8]  = '{32'h400,  32'hDEADBEEF, 3'd2, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h40A52023, 32'h0, 2'd0, 1'b1, 4'hF, 32'hDEADBEEF, 32'h400,      1'b0};
        tbl[9]  = '{32'h500,  32'h0, 3'd3, 5'd12, 1'b1,1'b0,1'b1,1'b1,1'b0, 32'h50053603, 32'h0,        2'd0, 1'b0, 4'h0, 32'h0,        32'h500,      1'b1};
        tbl[10] = '{32'h500,  32'h11, 3'd4, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h50A54023, 32'h0,        2'd0, 1'b0, 4'h0, 32'h0,        32'h500,      1'b1};
        tbl[11] = '{32'h500,  32'h0, 3'd2, 5'd13, 1'b1,1'b1,1'b1,1'b1,1'b0, 32'h50052683, 32'h0,        2'd0, 1'b0, 4'h0, 32'h0,        32'h500,      1'b1};
        tbl[12] = '{32'h101,  32'h77, 3'd1, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h10A510A3, 32'h0,        2'd0, 1'b0, 4'h0, 32'h0,        32'h101,      1'b1};
        tbl[13] = '{32'h600,  32'h0, 3'd2, 5'd3,  1'b1,1'b0,1'b1,1'b0,1'b1, 32'h60052187, 32'hCAFEF00D, 2'd0, 1'b1, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[14] = '{32'h200,  32'h0, 3'd2, 5'd14, 1'b1,1'b0,1'b1,1'b1,1'b0, 32'h20052703, 32'h11223344, 2'd1, 1'b1, 4'h0, 32'h0,        32'h11223344, 1'b0};
        tbl[15] = '{32'h204,  32'h55667788, 3'd2, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h20A52223, 32'h0, 2'd2, 1'b1, 4'hF, 32'h55667788, 32'h204,      1'b0};

        // Reset state, with an access requested on the inputs meanwhile
        rst = 1'b0;
        idle_inputs();
        MemRead_in = 1'b1; funct3_in = 3'd2; ALU_in = 32'h100;
        dm_ready = 1'b0; dm_rdata = 32'h0;
        #3;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        tick();
        chk("post-reset req", dm_req, 0);

        // Directed table
        for (int i = 0; i < 16; i++) run_op($sformatf("tbl%0d", i), tbl[i]);

        // Reset while a load waits for memory
        idle_inputs();
        MemRead_in = 1'b1; MemtoReg_in = 1'b1; RegWrite_in = 1'b1;
        funct3_in = 3'd2; ALU_in = 32'h700; Rd_in = 5'd15; Instruction_in = 32'h70052783;
        dm_ready = 1'b0;
        tick();
        chk("rstwait pending req", dm_req, 1);
        rst = 1'b0;
        #1;
        chk_reset("rstwait");
        idle_inputs();
        dm_ready = 1'b1; dm_rdata = 32'hDEAD0000;
        #1 rst = 1'b1;
        tick();
        chk("rstwait no req",     dm_req, 0);
        chk("rstwait no stall",   mem_stall, 0);
        chk("rstwait no wb",      RegWrite_out, 0);
        chk("rstwait wbdata",     WBData_out, 0);
        tick();
        chk("rstwait no wb late", {RegWrite_out, MemtoReg_out}, 0);
        dm_ready = 1'b0;

        // Random accesses against the model
        for (int n = 0; n < 150; n++) begin
            int kind = int'($urandom % 8);
            o = '0;
            o.alu   = $urandom;
            o.sdata = $urandom;
            o.f3    = 3'($urandom % 8);
            o.rd    = 5'($urandom);
            o.instr = $urandom;
            o.rdata = $urandom;
            o.delay = 2'($urandom % 4);
            o.mr    = (kind < 3) || (kind == 7);
            o.mw    = (kind >= 3 && kind < 6) || (kind == 7);
            o.m2r   = o.mr;
            o.rw    = (kind == 6) ? 1'($urandom) : (o.mr && !o.mw ? 1'($urandom) : 1'b0);
            o.frw   = o.mr && !o.mw && !o.rw;
            run_op($sformatf("rnd%0d", n), model(o));
        end

        idle_inputs();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
